// File: rtl/hazard_pkg.sv
// Shared types for the hazard/forwarding controller: forward-select codes,
// the shadow-pipeline tag and the tag-match helper.
package hazard_pkg;

  // Tag rd field is sized for the widest register address we support;
  // narrower addresses are zero-extended into it.
  localparam int TAG_AW = 8;

  typedef enum logic [1:0] {
    FWD_RF     = 2'b00,
    FWD_MEM_WB = 2'b01,
    FWD_EX_MEM = 2'b10
  } fwd_sel_t;

  typedef struct packed {
    logic              valid;
    logic [TAG_AW-1:0] rd;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
  } pipe_tag_t;

  localparam pipe_tag_t TAG_NONE = '0;

  // True when the tagged instruction will write a nonzero register equal to addr.
  function automatic logic tag_writes(input pipe_tag_t tag, input logic [TAG_AW-1:0] addr);
    return tag.valid && tag.reg_write && (tag.rd != '0) && (tag.rd == addr);
  endfunction

endpackage

// File: rtl/hazard_forward_ctrl_fwd_select.sv
// One EX operand's forward select: EX/MEM result wins over MEM/WB.
module fwd_select
  import hazard_pkg::*;
#(
  parameter int AW = 5
) (
  input  logic [AW-1:0] rs,
  input  pipe_tag_t     mem_tag,
  input  pipe_tag_t     wb_tag,
  output fwd_sel_t      sel
);

  logic [TAG_AW-1:0] rs_ext;

  assign rs_ext = TAG_AW'(rs);

  // Priority compare: youngest producer (EX/MEM) first.
  always_comb begin
    sel = FWD_RF;
    if (tag_writes(mem_tag, rs_ext)) begin
      sel = FWD_EX_MEM;
    end else if (tag_writes(wb_tag, rs_ext)) begin
      sel = FWD_MEM_WB;
    end
  end

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Hazard and forwarding controller: shadow pipeline of destination tags,
// per-operand forward selects, load-use bubble insertion, memory freeze with
// a sticky timeout flag and a saturating stall-cycle counter.
module hazard_forward_ctrl
  import hazard_pkg::*;
#(
  parameter int AW          = 5,
  parameter int NUM_SRC     = 2,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   id_valid,
  input  logic [NUM_SRC*AW-1:0]  id_rs,
  input  logic [AW-1:0]          id_rd,
  input  logic                   id_reg_write,
  input  logic                   id_mem_read,
  input  logic                   id_mem_write,
  input  logic                   flush,
  input  logic                   mem_ready,
  output logic [NUM_SRC*2-1:0]   forward,
  output logic                   stall_id,
  output logic                   bubble_ex,
  output logic                   stall_all,
  output logic                   mem_timeout,
  output logic [CNT_W-1:0]       stall_cnt
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(MEM_TIMEOUT - 1);

  pipe_tag_t             id_tag;
  pipe_tag_t             ex_tag;
  pipe_tag_t             mem_tag;
  pipe_tag_t             wb_tag;
  logic [NUM_SRC*AW-1:0] ex_rs;
  logic [NUM_SRC-1:0]    rs_hit;
  logic                  load_use;
  logic                  freeze;
  logic                  wait_done;
  logic [WAIT_W-1:0]     wait_rem;
  logic                  timeout_q;

  // ID-stage fields packed into a tag for the EX shadow register.
  always_comb begin
    id_tag           = TAG_NONE;
    id_tag.valid     = id_valid;
    id_tag.rd        = TAG_AW'(id_rd);
    id_tag.reg_write = id_reg_write;
    id_tag.mem_read  = id_mem_read;
    id_tag.mem_write = id_mem_write;
  end

  // Load-use: a load in EX feeding any ID source operand.
  always_comb begin
    rs_hit = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      rs_hit[i] = ex_tag.mem_read && tag_writes(ex_tag, TAG_AW'(id_rs[i*AW +: AW]));
    end
    load_use = id_valid && (|rs_hit);
  end

  // Stall outputs; freeze overrides load-use, and flush removes the consumer.
  always_comb begin
    freeze    = mem_tag.valid && (mem_tag.mem_read || mem_tag.mem_write) && !mem_ready;
    stall_all = freeze;
    stall_id  = load_use && !freeze && !flush;
    bubble_ex = stall_id;
  end

  // Shadow pipeline advance: hold on freeze, inject an empty EX slot on
  // flush or load-use, otherwise shift ID into EX. ex_rs only changes on a
  // real advance so forward stays stable across a freeze.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_tag  <= TAG_NONE;
      mem_tag <= TAG_NONE;
      wb_tag  <= TAG_NONE;
      ex_rs   <= '0;
    end else if (freeze) begin
      ex_tag  <= ex_tag;
      mem_tag <= mem_tag;
      wb_tag  <= wb_tag;
    end else if (flush || load_use) begin
      ex_tag  <= TAG_NONE;
      mem_tag <= ex_tag;
      wb_tag  <= mem_tag;
    end else begin
      ex_tag  <= id_tag;
      ex_rs   <= id_rs;
      mem_tag <= ex_tag;
      wb_tag  <= mem_tag;
    end
  end

  // Per-operand forward selects.
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_fwd
    fwd_select #(
      .AW (AW)
    ) u_fwd_select (
      .rs      (ex_rs[i*AW +: AW]),
      .mem_tag (mem_tag),
      .wb_tag  (wb_tag),
      .sel     (forward[2*i +: 2])
    );
  end

  // Terminal count is hit on the MEM_TIMEOUT-th consecutive freeze cycle, so
  // the flag is visible in that same cycle and latched for good afterwards.
  assign wait_done   = freeze && (wait_rem == '0);
  assign mem_timeout = timeout_q || wait_done;

  // Freeze wait down-counter, reloaded whenever the pipeline is not frozen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_rem <= WAIT_LOAD;
    end else if (!freeze) begin
      wait_rem <= WAIT_LOAD;
    end else if (wait_rem != '0) begin
      wait_rem <= wait_rem - 1'b1;
    end
  end

  // Sticky timeout flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout_q <= 1'b0;
    end else if (wait_done) begin
      timeout_q <= 1'b1;
    end
  end

  // Saturating count of stalled cycles (load-use and memory freeze).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if ((stall_all || stall_id) && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Directed bench for hazard_forward_ctrl with hand-computed expectations.
module tb_hazard_forward_ctrl;

  localparam int AW          = 5;
  localparam int NUM_SRC     = 2;
  localparam int MEM_TIMEOUT = 2;
  localparam int CNT_W       = 16;

  logic                  clk;
  logic                  rst_n;
  logic                  id_valid;
  logic [NUM_SRC*AW-1:0] id_rs;
  logic [AW-1:0]         id_rd;
  logic                  id_reg_write;
  logic                  id_mem_read;
  logic                  id_mem_write;
  logic                  flush;
  logic                  mem_ready;
  logic [NUM_SRC*2-1:0]  forward;
  logic                  stall_id;
  logic                  bubble_ex;
  logic                  stall_all;
  logic                  mem_timeout;
  logic [CNT_W-1:0]      stall_cnt;

  int n_vec = 0;
  int n_err = 0;

  hazard_forward_ctrl #(
    .AW          (AW),
    .NUM_SRC     (NUM_SRC),
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .CNT_W       (CNT_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_valid     (id_valid),
    .id_rs        (id_rs),
    .id_rd        (id_rd),
    .id_reg_write (id_reg_write),
    .id_mem_read  (id_mem_read),
    .id_mem_write (id_mem_write),
    .flush        (flush),
    .mem_ready    (mem_ready),
    .forward      (forward),
    .stall_id     (stall_id),
    .bubble_ex    (bubble_ex),
    .stall_all    (stall_all),
    .mem_timeout  (mem_timeout),
    .stall_cnt    (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] rs0, input logic [4:0] rs1,
                       input logic [4:0] rd, input logic rw, input logic mr, input logic mw);
    id_valid     = v;
    id_rs        = {rs1, rs0};
    id_rd        = rd;
    id_reg_write = rw;
    id_mem_read  = mr;
    id_mem_write = mw;
  endtask

  task automatic nop();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // Advance one clock; inputs are changed 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    mem_ready = 1'b1;
    nop();
    #2;
    chk("rst_forward",   32'(forward),     32'h0);
    chk("rst_stall_id",  32'(stall_id),    32'h0);
    chk("rst_stall_all", 32'(stall_all),   32'h0);
    chk("rst_timeout",   32'(mem_timeout), 32'h0);
    chk("rst_stall_cnt", 32'(stall_cnt),   32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // ADD x5,x1,x2 ; SUB x6,x5,x5 ; ADD x10,x1,x2
    drive(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0);
    settle();
    chk("t1_add_nostall", 32'(stall_id), 32'h0);
    tick();
    drive(1'b1, 5'd5, 5'd5, 5'd6, 1'b1, 1'b0, 1'b0);
    settle();
    chk("t1_sub_nostall", 32'(stall_id), 32'h0);
    tick();
    drive(1'b1, 5'd1, 5'd2, 5'd10, 1'b1, 1'b0, 1'b0);
    settle();
    chk("t1_sub_fwd", 32'(forward), 32'h0000000A);
    tick();
    nop();
    settle();
    chk("t1_indep_fwd", 32'(forward), 32'h0);
    tick();

    // ADD x5 ; ADD x5 ; SUB x7,x5,x1 -> EX/MEM wins
    drive(1'b1, 5'd1, 5'd1, 5'd5, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd1, 5'd1, 5'd5, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd5, 5'd1, 5'd7, 1'b1, 1'b0, 1'b0);
    tick();
    nop();
    settle();
    chk("t2_double_fwd", 32'(forward), 32'h00000002);
    tick();
    nop();
    tick();

    // LW x8 ; ADD x9,x8,x0 -> one bubble, then MEM/WB forward
    drive(1'b1, 5'd2, 5'd2, 5'd8, 1'b1, 1'b1, 1'b0);
    tick();
    drive(1'b1, 5'd8, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0);
    settle();
    chk("t3_stall_id",  32'(stall_id),  32'h1);
    chk("t3_bubble_ex", 32'(bubble_ex), 32'h1);
    chk("t3_no_freeze", 32'(stall_all), 32'h0);
    tick();
    settle();
    chk("t3_one_cycle",  32'(stall_id),  32'h0);
    chk("t3_stall_cnt1", 32'(stall_cnt), 32'h1);
    tick();
    nop();
    settle();
    chk("t3_wb_fwd",     32'(forward),   32'h00000001);
    chk("t3_stall_cnt2", 32'(stall_cnt), 32'h1);
    tick();

    // x0 writer/reader and LW x0 -> no forward, no stall
    drive(1'b1, 5'd1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd0, 5'd0, 5'd15, 1'b1, 1'b0, 1'b0);
    tick();
    nop();
    settle();
    chk("t4_x0_fwd", 32'(forward), 32'h0);
    tick();
    drive(1'b1, 5'd1, 5'd1, 5'd0, 1'b1, 1'b1, 1'b0);
    tick();
    drive(1'b1, 5'd0, 5'd0, 5'd15, 1'b1, 1'b0, 1'b0);
    settle();
    chk("t4_x0_nostall", 32'(stall_id),  32'h0);
    chk("t4_x0_nobub",   32'(bubble_ex), 32'h0);
    tick();
    nop();
    tick();

    // ADD x13 ; LW x8,(x13) ; ADD x11,x13,x3 ; ADD x14,x11,x0 with 3 wait cycles
    drive(1'b1, 5'd1, 5'd1, 5'd13, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd13, 5'd0, 5'd8, 1'b1, 1'b1, 1'b0);
    tick();
    drive(1'b1, 5'd13, 5'd3, 5'd11, 1'b1, 1'b0, 1'b0);
    settle();
    chk("t5_lw_fwd", 32'(forward), 32'h00000002);
    tick();
    drive(1'b1, 5'd11, 5'd0, 5'd14, 1'b1, 1'b0, 1'b0);
    mem_ready = 1'b0;
    settle();
    chk("t5_w1_stall_all", 32'(stall_all),   32'h1);
    chk("t5_w1_stall_id",  32'(stall_id),    32'h0);
    chk("t5_w1_fwd",       32'(forward),     32'h00000001);
    chk("t5_w1_timeout",   32'(mem_timeout), 32'h0);
    tick();
    settle();
    chk("t5_w2_stall_all", 32'(stall_all),   32'h1);
    chk("t5_w2_fwd",       32'(forward),     32'h00000001);
    chk("t5_w2_timeout",   32'(mem_timeout), 32'h1);
    tick();
    settle();
    chk("t5_w3_stall_all", 32'(stall_all),   32'h1);
    chk("t5_w3_fwd",       32'(forward),     32'h00000001);
    chk("t5_w3_stall_cnt", 32'(stall_cnt),   32'h3);
    tick();
    mem_ready = 1'b1;
    settle();
    chk("t5_end_stall_all", 32'(stall_all),   32'h0);
    chk("t5_end_fwd",       32'(forward),     32'h00000001);
    chk("t5_end_stall_cnt", 32'(stall_cnt),   32'h4);
    chk("t5_end_timeout",   32'(mem_timeout), 32'h1);
    tick();
    nop();
    settle();
    chk("t5_resume_fwd",     32'(forward),     32'h00000002);
    chk("t5_sticky_timeout", 32'(mem_timeout), 32'h1);
    chk("t5_final_cnt",      32'(stall_cnt),   32'h4);
    tick();

    // LW x8 ; LW x9,(x8) with flush ; ADD x10,x9,x0 -> no stall anywhere
    drive(1'b1, 5'd1, 5'd1, 5'd8, 1'b1, 1'b1, 1'b0);
    tick();
    drive(1'b1, 5'd8, 5'd0, 5'd9, 1'b1, 1'b1, 1'b0);
    flush = 1'b1;
    settle();
    chk("t6_flush_nostall", 32'(stall_id),  32'h0);
    chk("t6_flush_nobub",   32'(bubble_ex), 32'h0);
    tick();
    flush = 1'b0;
    drive(1'b1, 5'd9, 5'd0, 5'd10, 1'b1, 1'b0, 1'b0);
    settle();
    chk("t6_ex_invalid", 32'(stall_id),  32'h0);
    chk("t6_cnt_same",   32'(stall_cnt), 32'h4);
    tick();

    // LW x8 reaches MEM and waits; reset lands mid-freeze
    drive(1'b1, 5'd1, 5'd1, 5'd8, 1'b1, 1'b1, 1'b0);
    tick();
    nop();
    tick();
    mem_ready = 1'b0;
    settle();
    chk("t7_frozen",      32'(stall_all), 32'h1);
    chk("t7_cnt_pre_rst", 32'(stall_cnt), 32'h4);
    rst_n = 1'b0;
    #1;
    chk("t7_rst_stall_all", 32'(stall_all),   32'h0);
    chk("t7_rst_forward",   32'(forward),     32'h0);
    chk("t7_rst_stall_id",  32'(stall_id),    32'h0);
    chk("t7_rst_bubble",    32'(bubble_ex),   32'h0);
    chk("t7_rst_timeout",   32'(mem_timeout), 32'h0);
    chk("t7_rst_stall_cnt", 32'(stall_cnt),   32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    mem_ready = 1'b1;
    tick();
    settle();
    chk("t7_post_rst_stall_all", 32'(stall_all), 32'h0);
    chk("t7_post_rst_cnt",       32'(stall_cnt), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_forward_ctrl.md
# hazard_forward_ctrl

Parametrised hazard and forwarding controller for the in-order integer pipeline (IF/ID/EX/MEM/WB). It owns a shadow pipeline of destination tags and produces per-operand EX-stage forward selects, handling up to NUM_SRC source operands. It also detects load-use hazards, inserting one bubble each, and freezes the pipeline while a multi-cycle data-memory access is outstanding, with a timeout flag. It sits beside the ID/EX control path and drives the pipeline-register enables and operand muxes.

## Interface
- AW, 5: register address width
- NUM_SRC, 2: source operands per instruction (1..3)
- MEM_TIMEOUT, 255: wait cycles before `mem_timeout` sets (≥1)
- CNT_W, 16: width of `stall_cnt`
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous, active-low reset
- id_valid  in  1  valid instruction in ID
- id_rs  in  NUM_SRC*AW  ID source addresses, operand i at [i*AW +: AW]
- id_rd  in  AW  ID destination
- id_reg_write  in  1  ID instruction writes rd
- id_mem_read  in  1  ID instruction is a load
- id_mem_write  in  1  ID instruction is a store
- flush  in  1  taken branch/jump; discard ID instruction
- mem_ready  in  1  data memory completes the access in MEM this cycle
- forward  out  NUM_SRC*2  EX operand selects, operand i at [2i +: 2]
- stall_id  out  1  hold PC and IF/ID
- bubble_ex  out  1  load NOP into ID/EX
- stall_all  out  1  freeze all pipeline registers
- mem_timeout  out  1  sticky: memory wait exceeded MEM_TIMEOUT
- stall_cnt  out  CNT_W  saturating count of stall cycles (load-use + memory)

## Operation
- Tags ex_tag, mem_tag, wb_tag each hold {valid, rd, reg_write, mem_read, mem_write}; ex_rs holds NUM_SRC addresses.
- Forward encoding:
  - 00: register file
  - 10: EX/MEM, when mem_tag valid, reg_write, rd≠0 and rd==ex_rs[i]
  - 01: MEM/WB, the same test against wb_tag, applied only if the EX/MEM test fails
  - EX/MEM has priority (double hazard). A tag with valid=0 never matches.
- Load-use: id_valid and ex_tag {valid, mem_read, reg_write, rd≠0} and rd == any id_rs[i] → stall_id=1, bubble_ex=1.
- Memory freeze: mem_tag valid and (mem_read|mem_write) and !mem_ready → stall_all=1. stall_id and bubble_ex are forced to 0 while frozen.
- Per-cycle update, in priority order:
  1. Freeze: all tags hold.
  2. flush: ex_tag←invalid, mem_tag←ex_tag, wb_tag←mem_tag. Load-use is suppressed (stall_id=0).
  3. Load-use: the same shift as flush, with ex_tag←invalid.
  4. Normal: ex_tag←ID fields (valid=id_valid), ex_rs←id_rs, mem_tag←ex_tag, wb_tag←mem_tag.
- Freeze wait counter:
  - Counts freeze cycles and clears when a freeze ends.
  - When it reaches MEM_TIMEOUT, mem_timeout←1. It stays 1 until reset.
  - The freeze itself continues.
- stall_cnt increments on every cycle with stall_all or stall_id and saturates at all-ones.

## Timing
- forward, stall_id, bubble_ex, stall_all are combinational from registered tags plus current inputs. No extra latency: valid in the same cycle.
- An instruction accepted in ID at cycle t gets its forward selects during cycle t+1 (in EX).
- Load-use costs exactly one cycle. At t+2 the dependent instruction is in EX with forward=01 for the load operand.
- A freeze adds one cycle per !mem_ready cycle. forward holds stable during a freeze.
- Reset (asynchronous, any cycle including mid-freeze) clears:
  - all tags invalid, so forward=all 00 and stall_id=bubble_ex=stall_all=0
  - wait counter, mem_timeout and stall_cnt to 0
- Simultaneous flush and load-use: flush wins, no stall.
- Simultaneous freeze and flush: flush is ignored. Upstream holds flush until stall_all drops.

## Structure
- Shared package hazard_pkg: fwd_sel_t with constants FWD_RF=2'b00, FWD_MEM_WB=2'b01, FWD_EX_MEM=2'b10, and the pipe_tag_t struct.
- Sub-module fwd_select: one operand's priority compare (ex_rs vs mem_tag/wb_tag → fwd_sel_t), generated NUM_SRC times.
- Top module holds tags, load-use detect, freeze/timeout counter and stall_cnt.

## Test plan
- ADD x5 then SUB x6,x5,x5 back-to-back → forward=10,10 in SUB's EX cycle; next independent instruction → 00.
- ADD x5; ADD x5; SUB x7,x5,x1 → forward[0]=10 (EX/MEM wins over MEM/WB), forward[1]=00.
- LW x8 then ADD x9,x8,x0 → stall_id=bubble_ex=1 for one cycle, then ADD's EX has forward[0]=01, stall_cnt=1.
- Write to x0 followed by a reader of x0, and LW x0 followed by a user → forward=00, no stall.
- LW in MEM with mem_ready=0 for 3 cycles → stall_all=1 for 3 cycles, tags frozen, stall_cnt=3. With MEM_TIMEOUT=2, mem_timeout rises on the 2nd wait cycle and stays high.
- Load-use with flush in the same cycle → no stall, ex_tag invalid. Assert rst_n low mid-freeze → all outputs 0 immediately.
